// File: rtl/ram_bridge.sv
// Bridges Minimig's async-SRAM-style chip/kick RAM pins onto a req/ack word
// interface, launching at most one access per 7 MHz bus cycle.
module ram_bridge #(
    parameter int ACK_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clk_7m,
    input  logic [17:0] ram_a,
    input  logic [7:0]  ram_bank,
    input  logic [15:0] ram_dout,
    input  logic        ram_we,
    input  logic [1:0]  ram_be,
    input  logic        ram_oe,
    output logic [15:0] ram_din,
    output logic        mem_req,
    output logic        mem_we,
    output logic [20:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        overrun,
    output logic        bank_err
);

    localparam int CNT_W = $clog2(ACK_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    function automatic logic [2:0] lowest_bank(input logic [7:0] bank);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bank[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               clk_7m_q_r;
    logic               launch_r;
    logic [CNT_W-1:0]   lat_cnt_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic [20:0]        mem_addr_r;
    logic [15:0]        mem_wdata_r;
    logic [1:0]         mem_be_r;
    logic [15:0]        rdata_r;
    logic               overrun_r;
    logic               bank_err_r;

    logic               is_read_s;
    logic               is_write_s;
    logic               bank_any_s;
    logic               bank_multi_s;
    logic               valid_s;
    logic               start_s;
    logic               drop_s;
    logic               done_s;
    logic               late_s;
    logic               berr_s;
    logic               zero_read_s;

    // Bus-cycle edge detect: one launch pulse the clk cycle after clk_7m rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_7m_q_r <= 1'b0;
            launch_r   <= 1'b0;
        end else begin
            clk_7m_q_r <= clk_7m;
            launch_r   <= clk_7m & ~clk_7m_q_r;
        end
    end

    // Access decode, event strobes and next-state logic
    always_comb begin
        // Read wins when oe and we are both low; a write with no byte lanes is a no-op
        is_read_s    = ~ram_oe;
        is_write_s   = ram_oe & ~ram_we & (ram_be != 2'b11);
        bank_any_s   = (ram_bank != 8'h00);
        bank_multi_s = ((ram_bank & (ram_bank - 8'd1)) != 8'h00);
        valid_s      = (is_read_s | is_write_s) & bank_any_s;
        start_s      = launch_r & valid_s & (state_r == ST_IDLE);
        drop_s       = launch_r & valid_s & (state_r == ST_REQ);
        done_s       = mem_ack & (state_r == ST_REQ);
        late_s       = (state_r == ST_REQ) & ~mem_ack & (lat_cnt_r >= CNT_W'(ACK_LIMIT));
        berr_s       = launch_r & (is_read_s | is_write_s) & bank_multi_s;
        zero_read_s  = launch_r & is_read_s & ~bank_any_s & (state_r == ST_IDLE);
        state_s      = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request side: captured at launch and held stable until the ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 21'h000000;
            mem_wdata_r <= 16'h0000;
            mem_be_r    <= 2'b00;
        end else if (start_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= ~is_read_s;
            mem_addr_r  <= {lowest_bank(ram_bank), ram_a};
            mem_wdata_r <= ram_dout;
            mem_be_r    <= {~ram_be[0], ~ram_be[1]};
        end else if (done_s) begin
            mem_req_r   <= 1'b0;
        end
    end

    // Read-data register: updated on read completion, zeroed by a bankless read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_r <= 16'h0000;
        end else if (done_s && !mem_we_r) begin
            rdata_r <= mem_rdata;
        end else if (zero_read_s) begin
            rdata_r <= 16'h0000;
        end
    end

    // Ack latency counter and sticky status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt_r  <= '0;
            overrun_r  <= 1'b0;
            bank_err_r <= 1'b0;
        end else begin
            if (start_s) begin
                lat_cnt_r <= CNT_W'(1);
            end else if ((state_r == ST_REQ) && (lat_cnt_r < CNT_W'(ACK_LIMIT))) begin
                lat_cnt_r <= lat_cnt_r + CNT_W'(1);
            end
            overrun_r  <= overrun_r | drop_s | late_s;
            bank_err_r <= bank_err_r | berr_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign busy      = (state_r == ST_REQ);
    assign overrun   = overrun_r;
    assign bank_err  = bank_err_r;
    assign ram_din   = (ram_oe == 1'b0) ? rdata_r : 16'h0000;

endmodule
